pipeline_hazard_unit: RTL and testbench
=======================================

# pipeline_hazard_unit

Parametrised hazard, forwarding and stall controller for the 5-stage (IF/ID/EX/MEM/WB) pipeline processor. It keeps its own shadow copy of the destination-register pipeline from EX through WB. From that copy and the decoded ID-stage instruction it produces stall, kill and per-operand forwarding selects. It generalises the existing hazard detection in three ways: configurable operand count and register-address width, a multi-cycle EX operation with an internal occupancy counter, and forwarding that can be compiled out.

## Interface
Parameters:
- REG_ADDR_W, 3, register-address width
- NUM_SRC, 2, number of source operands checked per instruction (1..4)
- MC_LAT, 3, number of cycles a multi-cycle op occupies EX (>=2)
- R0_ZERO, 1, if 1, register 0 never creates a hazard

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_src  in  NUM_SRC*REG_ADDR_W  source register addresses; operand i is in bits [i*REG_ADDR_W +: REG_ADDR_W]
- id_src_used  in  NUM_SRC  per-operand "operand is read" flag
- id_rd  in  REG_ADDR_W  destination register
- id_reg_wr  in  1  instruction writes the register file
- id_mem_rd  in  1  instruction is a load
- id_multi  in  1  instruction is a multi-cycle EX op
- branch_taken  in  1  branch or jump resolved taken in ID
- stall  out  1  hold PC and IF/ID; insert a bubble into EX
- kill  out  1  squash the IF/ID instruction
- fwd  out  2*NUM_SRC  per-operand select: 00 regfile, 01 EX ALU result, 10 MEM result, 11 WB bus
- ex_busy  out  1  multi-cycle op still occupying EX
- ex_rd, mem_rd, wb_rd  out  REG_ADDR_W each  shadow destination registers
- ex_wr, mem_wr, wb_wr  out  1 each  shadow entry valid and writes a register

## Operation
- Shadow pipeline:
  - Each stage entry holds {valid, rd, reg_wr, mem_rd, multi}.
  - On each rising edge: WB<=MEM; MEM<=EX, or a bubble while EX holds.
  - EX is loaded with the ID instruction when it issues, with a bubble when stalled, and holds while ex_busy.
- Issue: the ID instruction issues when id_valid=1 and stall=0.
- Match rule: operand i matches a stage when id_src_used[i]=1, the stage entry has valid and reg_wr set, its rd equals id_src[i], and the address is not 0 when R0_ZERO=1.
- Forward priority, youngest first: EX (01), then MEM (10), then WB (11), else 00.
- Stall sources, combined by OR:
  - Load-use: an operand matches EX and the EX entry has mem_rd=1.
  - Structural: ex_busy=1.
  - Forwarding disabled: see Configuration.
- Multi-cycle counter:
  - Loaded with MC_LAT-1 when a multi op enters EX.
  - Decrements by 1 each cycle while nonzero.
  - ex_busy = (counter != 0).
  - The EX entry holds while ex_busy=1 and moves to MEM on the first cycle after the counter reaches 0.
- Kill: kill = branch_taken & id_valid & ~stall. A branch_taken presented while stalled is ignored; the decoder must re-present it.
- Simultaneous load-use and ex_busy: a single stall; no double bubble.
- While stall=1, fwd still reflects the current matches and is don't-care for the datapath.

## Timing
- stall, kill, fwd and ex_busy are combinational from the registered shadow state and the ID inputs. No extra latency is allowed.
- Shadow registers and the counter update on the rising edge of clk.
- Load-use costs exactly 1 stall cycle. The dependent instruction then forwards from MEM (10).
- A multi op causes MC_LAT-1 stall cycles for the following instruction.
- Reset:
  - While reset_n=0 at a rising edge, all shadow valid bits are cleared and the counter is set to 0.
  - While reset_n=0, stall, kill, ex_busy, all fwd bits and all *_wr outputs are forced to 0.
  - All *_rd outputs reset to 0.
  - Reset asserted during a multi-cycle op aborts it. ex_busy=0 on the first cycle after reset is released.

## Configuration
- Macro FORWARDING_EN.
- Defined: behaviour as described above.
- Not defined:
  - fwd is tied to 0.
  - stall also asserts when any operand matches EX, MEM or WB. The register file is not assumed write-through.
  - A RAW dependency on the immediately preceding instruction therefore costs 3 stall cycles.

## Test plan
- ADD r1 then ADD r2,r1,r3 back-to-back (FORWARDING_EN) -> stall=0 throughout; fwd[1:0]=01 in the second instruction's ID cycle.
- LW r4 then SUB r5,r4,r4 -> stall=1 for exactly 1 cycle; ex_wr=0 (bubble) on the next cycle; then fwd=10 for both operands.
- Multi op to r6 with MC_LAT=3, followed by an independent op -> ex_busy=1 and stall=1 for 2 cycles; mem_wr shows bubbles; r6 reaches WB 2 cycles later than a normal op.
- branch_taken=1 with stall=0 -> kill=1 that cycle. branch_taken=1 during a load-use stall -> kill=0.
- Write to r0 followed by a read of r0 (R0_ZERO=1) -> fwd=00 and stall=0. reset_n=0 asserted mid multi-cycle op -> all outputs 0; ex_busy=0 after release.
- FORWARDING_EN undefined: ADD r1 then a dependent op -> stall=1 for 3 cycles, fwd=00 throughout.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding and stall controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Latency: stall/kill/fwd/ex_busy are combinational from registered shadow state and ID inputs.
// Backpressure: stall holds PC and IF/ID and drops a bubble into EX; ex_busy holds EX in place.
//
// Ports:
//   clk, reset_n            : rising-edge clock, synchronous active-low reset
//   id_*                    : decoded ID-stage instruction (operand i at id_src[i*REG_ADDR_W +: REG_ADDR_W])
//   branch_taken            : branch/jump resolved taken in ID
//   stall, kill, fwd        : hazard controls; fwd per operand 00 rf, 01 EX, 10 MEM, 11 WB
//   ex_busy                 : multi-cycle op still occupying EX
//   {ex,mem,wb}_{rd,wr}     : shadow destination register and "valid and writes" flag per stage
// Build option: define FORWARDING_EN to enable operand forwarding; otherwise any RAW match stalls
// until the producer has left WB and fwd is tied to 0.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int MC_LAT     = 3,
  parameter int R0_ZERO    = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_wr,
  input  logic                          id_mem_rd,
  input  logic                          id_multi,
  input  logic                          branch_taken,
  output logic                          stall,
  output logic                          kill,
  output logic [2*NUM_SRC-1:0]          fwd,
  output logic                          ex_busy,
  output logic [REG_ADDR_W-1:0]         ex_rd,
  output logic [REG_ADDR_W-1:0]         mem_rd,
  output logic [REG_ADDR_W-1:0]         wb_rd,
  output logic                          ex_wr,
  output logic                          mem_wr,
  output logic                          wb_wr
);

  localparam int CNT_W = $clog2(MC_LAT);

  // Only EX needs mem_rd (load-use); the multi flag lives in the occupancy counter.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_wr;
    logic                  mem_rd;
  } ex_ent_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_wr;
  } ent_t;

  ex_ent_t            ex_q;
  ent_t               mem_q;
  ent_t               wb_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               busy;
  logic               load_use;
  logic               stall_int;
  logic               issue;
  logic [NUM_SRC-1:0] m_ex;
  logic [NUM_SRC-1:0] m_mem;
  logic [NUM_SRC-1:0] m_wb;

  // Per-operand match against each shadow stage.
  always_comb begin
    m_ex  = '0;
    m_mem = '0;
    m_wb  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] &&
          !((R0_ZERO != 0) && (id_src[i*REG_ADDR_W +: REG_ADDR_W] == '0))) begin
        m_ex[i]  = ex_q.valid  && ex_q.reg_wr  && (ex_q.rd  == id_src[i*REG_ADDR_W +: REG_ADDR_W]);
        m_mem[i] = mem_q.valid && mem_q.reg_wr && (mem_q.rd == id_src[i*REG_ADDR_W +: REG_ADDR_W]);
        m_wb[i]  = wb_q.valid  && wb_q.reg_wr  && (wb_q.rd  == id_src[i*REG_ADDR_W +: REG_ADDR_W]);
      end
    end
  end

  assign busy     = (cnt_q != '0);
  assign load_use = (|m_ex) & ex_q.mem_rd;

`ifdef FORWARDING_EN
  logic [2*NUM_SRC-1:0] fwd_int;

  // Youngest producer wins.
  always_comb begin
    fwd_int = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (m_ex[i])       fwd_int[2*i +: 2] = 2'b01;
      else if (m_mem[i]) fwd_int[2*i +: 2] = 2'b10;
      else if (m_wb[i])  fwd_int[2*i +: 2] = 2'b11;
    end
  end

  assign stall_int = load_use | busy;
  assign fwd       = reset_n ? fwd_int : '0;
`else
  logic any_match;

  // Without a bypass network the operand must wait until its producer has retired from WB.
  assign any_match = |(m_ex | m_mem | m_wb);
  assign stall_int = load_use | busy | any_match;
  assign fwd       = '0;
`endif

  assign issue   = id_valid & ~stall_int;

  assign stall   = reset_n & stall_int;
  assign kill    = reset_n & branch_taken & id_valid & ~stall_int;
  assign ex_busy = reset_n & busy;

  assign ex_rd   = ex_q.rd;
  assign mem_rd  = mem_q.rd;
  assign wb_rd   = wb_q.rd;
  assign ex_wr   = reset_n & ex_q.valid  & ex_q.reg_wr;
  assign mem_wr  = reset_n & mem_q.valid & mem_q.reg_wr;
  assign wb_wr   = reset_n & wb_q.valid  & wb_q.reg_wr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q <= mem_q;
      if (busy) begin
        // EX holds the multi-cycle op; MEM sees a bubble. stall_int is high so nothing issues.
        mem_q <= '0;
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_wr: ex_q.reg_wr};
        if (issue) begin
          ex_q  <= '{valid: 1'b1, rd: id_rd, reg_wr: id_reg_wr, mem_rd: id_mem_rd};
          cnt_q <= id_multi ? CNT_W'(MC_LAT - 1) : '0;
        end else begin
          ex_q  <= '0;
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Randomized + directed bench for pipeline_hazard_unit against a timeline model:
// each issued instruction is tracked by the cycle it enters EX and the cycle it reaches MEM.
// Works with or without FORWARDING_EN defined.
module tb_pipeline_hazard_unit;

  localparam int W   = 3;
  localparam int NS  = 2;
  localparam int MCL = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              id_valid;
  logic [NS*W-1:0]   id_src;
  logic [NS-1:0]     id_src_used;
  logic [W-1:0]      id_rd;
  logic              id_reg_wr;
  logic              id_mem_rd;
  logic              id_multi;
  logic              branch_taken;
  logic              stall;
  logic              kill;
  logic [2*NS-1:0]   fwd;
  logic              ex_busy;
  logic [W-1:0]      ex_rd;
  logic [W-1:0]      mem_rd;
  logic [W-1:0]      wb_rd;
  logic              ex_wr;
  logic              mem_wr;
  logic              wb_wr;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(
    .REG_ADDR_W (W),
    .NUM_SRC    (NS),
    .MC_LAT     (MCL),
    .R0_ZERO    (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_rd        (id_rd),
    .id_reg_wr    (id_reg_wr),
    .id_mem_rd    (id_mem_rd),
    .id_multi     (id_multi),
    .branch_taken (branch_taken),
    .stall        (stall),
    .kill         (kill),
    .fwd          (fwd),
    .ex_busy      (ex_busy),
    .ex_rd        (ex_rd),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .ex_wr        (ex_wr),
    .mem_wr       (mem_wr),
    .wb_wr        (wb_wr)
  );

  // One record per issued instruction: EX during [enter, mem_c), MEM at mem_c, WB at mem_c+1.
  typedef struct {
    int rd;
    bit wr;
    bit ld;
    bit mc;
    int enter;
    int mem_c;
  } rec_t;

  rec_t hist[$];
  int   t = 0;
  int   total = 0;
  int   bad = 0;
  bit   last_stall;

`ifdef FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0d obs=%0h exp=%0h", tag, t, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, advance the model.
  task automatic cyc(input bit rst, input bit v, input logic [W-1:0] s0, input logic [W-1:0] s1,
                     input logic [1:0] used, input logic [W-1:0] rd, input bit wr, input bit ld,
                     input bit mc, input bit br);
    int st_rd[3];
    bit st_v[3];
    bit st_wr[3];
    int src[NS];
    int fw[NS];
    bit ex_ld;
    bit busy;
    bit lu;
    bit anym;
    bit stall_m;
    logic [2*NS-1:0] fwd_exp;

    @(negedge clk);
    reset_n      = rst;
    id_valid     = v;
    id_src       = {s1, s0};
    id_src_used  = used;
    id_rd        = rd;
    id_reg_wr    = wr;
    id_mem_rd    = ld;
    id_multi     = mc;
    branch_taken = br;
    #1;

    for (int s = 0; s < 3; s++) begin
      st_rd[s] = 0; st_v[s] = 0; st_wr[s] = 0;
    end
    ex_ld = 0; busy = 0;
    foreach (hist[k]) begin
      int s;
      s = (t >= hist[k].enter && t < hist[k].mem_c) ? 0 :
          (t == hist[k].mem_c)                      ? 1 :
          (t == hist[k].mem_c + 1)                  ? 2 : -1;
      if (s >= 0) begin
        st_v[s] = 1; st_rd[s] = hist[k].rd; st_wr[s] = hist[k].wr;
        if (s == 0) begin
          ex_ld = hist[k].ld;
          if (hist[k].mc && t < hist[k].enter + MCL - 1) busy = 1;
        end
      end
    end

    src[0] = int'(s0);
    src[1] = int'(s1);
    lu = 0; anym = 0;
    fwd_exp = '0;
    for (int i = 0; i < NS; i++) begin
      fw[i] = 0;
      if (used[i] && src[i] != 0) begin
        for (int s = 2; s >= 0; s--)
          if (st_v[s] && st_wr[s] && st_rd[s] == src[i]) fw[i] = s + 1;
      end
      if (fw[i] != 0) anym = 1;
      if (fw[i] == 1 && ex_ld) lu = 1;
      if (FWD_ON) fwd_exp[2*i +: 2] = 2'(fw[i]);
    end
    stall_m = lu || busy || (!FWD_ON && anym);
    last_stall = stall_m;

    check("stall",   32'(stall),   32'(rst & stall_m));
    check("kill",    32'(kill),    32'(rst & br & v & ~stall_m));
    check("ex_busy", 32'(ex_busy), 32'(rst & busy));
    check("fwd",     32'(fwd),     rst ? 32'(fwd_exp) : 32'd0);
    check("ex_rd",   32'(ex_rd),   32'(st_rd[0]));
    check("mem_rd",  32'(mem_rd),  32'(st_rd[1]));
    check("wb_rd",   32'(wb_rd),   32'(st_rd[2]));
    check("ex_wr",   32'(ex_wr),   32'(rst & st_v[0] & st_wr[0]));
    check("mem_wr",  32'(mem_wr),  32'(rst & st_v[1] & st_wr[1]));
    check("wb_wr",   32'(wb_wr),   32'(rst & st_v[2] & st_wr[2]));

    @(posedge clk);
    if (!rst) begin
      hist.delete();
    end else if (v && !stall_m) begin
      rec_t r;
      r.rd = int'(rd); r.wr = wr; r.ld = ld; r.mc = mc;
      r.enter = t + 1;
      r.mem_c = t + 1 + (mc ? MCL : 1);
      hist.push_back(r);
    end
    t++;
    while (hist.size() > 0 && hist[0].mem_c + 1 < t) void'(hist.pop_front());
  endtask

  // Present an instruction until it issues (decoder re-presents while stalled).
  task automatic put(input logic [W-1:0] s0, input logic [W-1:0] s1, input logic [1:0] used,
                     input logic [W-1:0] rd, input bit wr, input bit ld, input bit mc, input bit br);
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1, s0, s1, used, rd, wr, ld, mc, br);
      if (!last_stall) return;
    end
    check("issue_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 0; id_valid = 0; id_src = '0; id_src_used = '0; id_rd = '0;
    id_reg_wr = 0; id_mem_rd = 0; id_multi = 0; branch_taken = 0;

    // Reset state
    cyc(0, 1, 1, 2, 2'b11, 3, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

    // ADD r1 ; ADD r2,r1,r3
    put(0, 0, 2'b00, 1, 1, 0, 0, 0);
    put(1, 3, 2'b11, 2, 1, 0, 0, 0);
    idle(4);

    // LW r4 ; SUB r5,r4,r4 with a branch presented during the load-use stall
    put(0, 0, 2'b00, 4, 1, 1, 0, 0);
    put(4, 4, 2'b11, 5, 1, 0, 0, 1);
    idle(4);

    // Multi op to r6, then an independent op
    put(0, 0, 2'b00, 6, 1, 0, 1, 0);
    put(1, 2, 2'b11, 7, 1, 0, 0, 1);
    idle(5);

    // Write r0 then read r0
    put(0, 0, 2'b00, 0, 1, 0, 0, 0);
    put(0, 0, 2'b11, 3, 1, 0, 0, 0);
    idle(4);

    // Reset in the middle of a multi-cycle op
    put(0, 0, 2'b00, 6, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    cyc(0, 1, 6, 6, 2'b11, 1, 1, 0, 0, 1);
    cyc(1, 1, 6, 6, 2'b11, 1, 1, 0, 0, 0);
    idle(4);

    // Randomized traffic with small register space to create frequent hazards
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 40) != 0,
          $urandom_range(0, 3) != 0,
          W'($urandom_range(0, 7)),
          W'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)),
          W'($urandom_range(0, 7)),
          $urandom_range(0, 4) != 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
